// File: rtl/rx_write_sequencer.sv
// rx_write_sequencer: qualifies parsed RDMA WRITE headers, issues one DMA write command per
// accepted packet, gates or drains its payload. Optional payload stall timeout: RX_STREAM_TIMEOUT_EN.
module rx_write_sequencer #(
    parameter int          C_AXIS_TDATA_WIDTH = 32,
    parameter int          C_AXIS_TKEEP_WIDTH = 4,
    parameter logic [7:0]  OPCODE_WRITE       = 8'h0A,
    parameter logic [31:0] MAX_LEN            = 32'd4096,
    parameter int          CMD_ADDR_WIDTH     = 32,
    parameter int          TIMEOUT_CYCLES     = 1024
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          header_valid,
    input  logic [7:0]                    rdma_opcode,
    input  logic [23:0]                   rdma_psn,
    input  logic [63:0]                   rdma_remote_addr,
    input  logic [31:0]                   rdma_length,
    input  logic                          psn_load,
    input  logic [23:0]                   psn_init,
    input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic [C_AXIS_TKEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic                          s_axis_tlast,
    output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic [C_AXIS_TKEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic                          cmd_valid,
    input  logic                          cmd_ready,
    output logic [CMD_ADDR_WIDTH-1:0]     cmd_addr,
    output logic [31:0]                   cmd_len,
    output logic                          status_valid,
    output logic [2:0]                    status_code,
    output logic [23:0]                   expected_psn,
    output logic [15:0]                   pkt_count,
    output logic [15:0]                   drop_count,
    output logic                          busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_CMD    = 3'd2,
        S_STREAM = 3'd3,
        S_DROP   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic [7:0]                r_opcode;
    logic [23:0]               r_psn;
    logic [CMD_ADDR_WIDTH-1:0] r_addr;
    logic [31:0]               r_len;
    logic [2:0]                r_code;
    logic                      r_accepted;
    logic [31:0]               r_byte_cnt;
    logic [23:0]               r_expected_psn;
    logic [15:0]               r_pkt_count;
    logic [15:0]               r_drop_count;
    logic                      w_s_hs;
    logic                      w_timeout;
    logic [2:0]                w_check_code;
    logic [2:0]                w_done_code;
    logic                      w_unused_addr;

    function automatic logic [31:0] popcount(input logic [C_AXIS_TKEEP_WIDTH-1:0] keep);
        logic [31:0] cnt;
        cnt = 32'd0;
        for (int i = 0; i < C_AXIS_TKEEP_WIDTH; i++) begin
            cnt = cnt + {31'd0, keep[i]};
        end
        return cnt;
    endfunction

    // Only the low address bits reach the DMA command.
    assign w_unused_addr = ^rdma_remote_addr[63:CMD_ADDR_WIDTH];
    assign w_s_hs        = s_axis_tvalid && s_axis_tready;
    assign expected_psn  = r_expected_psn;
    assign pkt_count     = r_pkt_count;
    assign drop_count    = r_drop_count;
    assign busy          = (r_state != S_IDLE);

`ifdef RX_STREAM_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [STALL_W-1:0] r_stall;

    assign w_timeout = ((r_state == S_STREAM) || (r_state == S_DROP)) && !w_s_hs &&
                       ((r_stall + STALL_W'(1)) == STALL_W'(TIMEOUT_CYCLES));

    // Payload stall counter: counts cycles without an input handshake while waiting on payload.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_stall <= '0;
        end else if (((r_state == S_STREAM) || (r_state == S_DROP)) && !w_s_hs) begin
            r_stall <= r_stall + STALL_W'(1);
        end else begin
            r_stall <= '0;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Header qualification, highest-priority failure wins.
    always_comb begin
        if (r_opcode != OPCODE_WRITE) begin
            w_check_code = 3'd1;
        end else if (r_psn != r_expected_psn) begin
            w_check_code = 3'd2;
        end else if ((r_len == 32'd0) || (r_len > MAX_LEN)) begin
            w_check_code = 3'd3;
        end else begin
            w_check_code = 3'd0;
        end
    end

    // Completion code: accepted packets are judged on the delivered byte count.
    always_comb begin
        if (r_accepted) begin
            if (r_byte_cnt == r_len) begin
                w_done_code = 3'd0;
            end else begin
                w_done_code = 3'd4;
            end
        end else begin
            w_done_code = r_code;
        end
    end

    // State register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = header_valid ? S_CHECK : S_IDLE;
            S_CHECK:  w_next = (w_check_code != 3'd0) ? S_DROP : S_CMD;
            S_CMD:    w_next = cmd_ready ? S_STREAM : S_CMD;
            S_STREAM: w_next = (w_timeout || (w_s_hs && s_axis_tlast)) ? S_DONE : S_STREAM;
            S_DROP:   w_next = (w_timeout || (w_s_hs && s_axis_tlast)) ? S_DONE : S_DROP;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Output decode; everything is zero outside the state that owns it.
    always_comb begin
        s_axis_tready = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        cmd_valid     = 1'b0;
        cmd_addr      = '0;
        cmd_len       = 32'd0;
        status_valid  = 1'b0;
        status_code   = 3'd0;
        case (r_state)
            S_CMD: begin
                cmd_valid = 1'b1;
                cmd_addr  = r_addr;
                cmd_len   = r_len;
            end
            S_STREAM: begin
                m_axis_tdata  = s_axis_tdata;
                m_axis_tkeep  = s_axis_tkeep;
                m_axis_tvalid = s_axis_tvalid;
                m_axis_tlast  = s_axis_tlast;
                s_axis_tready = m_axis_tready;
            end
            S_DROP: begin
                s_axis_tready = 1'b1;
            end
            S_DONE: begin
                status_valid = 1'b1;
                status_code  = w_done_code;
            end
            default: begin
                s_axis_tready = 1'b0;
            end
        endcase
    end

    // Header latch, byte counter, expected PSN and packet counters.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_opcode       <= 8'd0;
            r_psn          <= 24'd0;
            r_addr         <= '0;
            r_len          <= 32'd0;
            r_code         <= 3'd0;
            r_accepted     <= 1'b0;
            r_byte_cnt     <= 32'd0;
            r_expected_psn <= 24'd0;
            r_pkt_count    <= 16'd0;
            r_drop_count   <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (header_valid) begin
                        r_opcode <= rdma_opcode;
                        r_psn    <= rdma_psn;
                        r_addr   <= rdma_remote_addr[CMD_ADDR_WIDTH-1:0];
                        r_len    <= rdma_length;
                    end
                    if (psn_load) begin
                        r_expected_psn <= psn_init;
                    end
                end
                S_CHECK: begin
                    r_code     <= w_check_code;
                    r_accepted <= (w_check_code == 3'd0);
                end
                S_STREAM: begin
                    if (w_timeout) begin
                        r_code     <= 3'd5;
                        r_accepted <= 1'b0;
                    end else if (w_s_hs) begin
                        r_byte_cnt <= r_byte_cnt + popcount(s_axis_tkeep);
                    end
                end
                S_DROP: begin
                    if (w_timeout) begin
                        r_code <= 3'd5;
                    end
                end
                S_DONE: begin
                    r_byte_cnt <= 32'd0;
                    if (r_accepted) begin
                        r_expected_psn <= r_expected_psn + 24'd1;
                        r_pkt_count    <= r_pkt_count + 16'd1;
                    end else begin
                        r_drop_count <= r_drop_count + 16'd1;
                    end
                end
                default: begin
                    r_byte_cnt <= r_byte_cnt;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_write_sequencer.sv
// Self-checking bench for rx_write_sequencer: directed vector table, reset and backpressure
// sequences, then randomized packets checked against a packet-level reference model.
module tb_rx_write_sequencer;

    logic        aclk;
    logic        aresetn;
    logic        header_valid;
    logic [7:0]  rdma_opcode;
    logic [23:0] rdma_psn;
    logic [63:0] rdma_remote_addr;
    logic [31:0] rdma_length;
    logic        psn_load;
    logic [23:0] psn_init;
    logic [31:0] s_axis_tdata;
    logic [3:0]  s_axis_tkeep;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_len;
    logic        status_valid;
    logic [2:0]  status_code;
    logic [23:0] expected_psn;
    logic [15:0] pkt_count;
    logic [15:0] drop_count;
    logic        busy;

    rx_write_sequencer #(.TIMEOUT_CYCLES(8)) dut (
        .aclk(aclk), .aresetn(aresetn), .header_valid(header_valid),
        .rdma_opcode(rdma_opcode), .rdma_psn(rdma_psn), .rdma_remote_addr(rdma_remote_addr),
        .rdma_length(rdma_length), .psn_load(psn_load), .psn_init(psn_init),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .status_valid(status_valid), .status_code(status_code), .expected_psn(expected_psn),
        .pkt_count(pkt_count), .drop_count(drop_count), .busy(busy)
    );

    typedef struct {
        logic        ld;
        logic [23:0] ld_val;
        logic [7:0]  op;
        logic [23:0] psn;
        logic [63:0] addr;
        logic [31:0] len;
        int          nb;
        logic [3:0]  lk;
        int          cdel;
        logic [2:0]  want;
    } vec_t;

    vec_t        tbl[11];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_status = 0;
    string       cur_tag = "init";
    logic [36:0] got_q[$];

    // Reference model state, updated per packet from the acceptance rules.
    logic [23:0] m_psn  = 24'd0;
    logic [15:0] m_pkt  = 16'd0;
    logic [15:0] m_drop = 16'd0;

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Output monitor on the falling edge.
    always @(negedge aclk) begin
        if (m_axis_tvalid && m_axis_tready) got_q.push_back({m_axis_tdata, m_axis_tkeep, m_axis_tlast});
        if (status_valid) n_status++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL [%s] %s: got 0x%0h, expected 0x%0h", cur_tag, name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [2:0] model_code(input logic [7:0] op, input logic [23:0] psn,
                                              input logic [31:0] len, input logic [31:0] bytes);
        if (op != 8'h0A) return 3'd1;
        if (psn != m_psn) return 3'd2;
        if ((len == 32'd0) || (len > 32'd4096)) return 3'd3;
        return (bytes == len) ? 3'd0 : 3'd4;
    endfunction

    task automatic load_psn(input logic [23:0] v);
        psn_load = 1'b1;
        psn_init = v;
        tick();
        psn_load = 1'b0;
        m_psn = v;
        check("psn_load", expected_psn, v);
    endtask

    task automatic run_pkt(input logic [7:0] op, input logic [23:0] psn, input logic [63:0] addr,
                           input logic [31:0] len, input int nb, input logic [3:0] lk,
                           input int cdel, input logic [2:0] want);
        logic [36:0] exp_q[$];
        logic        acc;
        logic        hs;
        int          st0;
        int          guard;
        int          nmis;
        logic [31:0] d;
        acc = (want == 3'd0) || (want == 3'd4);
        check("idle_before", busy, 1'b0);
        got_q.delete();
        st0 = n_status;
        rdma_opcode = op; rdma_psn = psn; rdma_remote_addr = addr; rdma_length = len;
        header_valid = 1'b1;
        tick();
        header_valid = 1'b0;
        check("cmd_valid_in_check", cmd_valid, 1'b0);
        tick();
        if (acc) begin
            check("cmd_valid", cmd_valid, 1'b1);
            check("cmd_addr", cmd_addr, addr[31:0]);
            check("cmd_len", cmd_len, len);
            for (int k = 0; k < cdel; k++) begin
                check("tready_in_cmd", s_axis_tready, 1'b0);
                if (k == 0) begin
                    psn_load = 1'b1; psn_init = 24'hABCDEF;
                    header_valid = 1'b1; rdma_length = 32'd999;
                end
                tick();
                psn_load = 1'b0; header_valid = 1'b0;
                check("cmd_valid_hold", cmd_valid, 1'b1);
                check("cmd_addr_hold", cmd_addr, addr[31:0]);
                check("cmd_len_hold", cmd_len, len);
            end
            cmd_ready = 1'b1;
            tick();
            cmd_ready = 1'b0;
            check("cmd_valid_after", cmd_valid, 1'b0);
        end else begin
            check("cmd_valid_reject", cmd_valid, 1'b0);
        end
        for (int b = 0; b < nb; b++) begin
            d = $urandom;
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = d;
            s_axis_tkeep  = (b == nb - 1) ? lk : 4'hF;
            s_axis_tlast  = (b == nb - 1);
            if (acc) exp_q.push_back({d, s_axis_tkeep, s_axis_tlast});
            guard = 0;
            hs = 1'b0;
            while (!hs && guard < 64) begin
                m_axis_tready = ($urandom_range(0, 3) != 0);
                #1;
                hs = s_axis_tready;
                tick();
                guard++;
            end
            if (!hs) begin
                n_tests++;
                n_fail++;
                $display("FAIL [%s] beat_accept: beat %0d not taken within 64 cycles", cur_tag, b);
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        check("status_valid", status_valid, 1'b1);
        check("status_code", status_code, want);
        tick();
        check("status_one_cycle", status_valid, 1'b0);
        check("busy_after", busy, 1'b0);
        if (acc) begin
            m_psn = m_psn + 24'd1;
            m_pkt = m_pkt + 16'd1;
        end else begin
            m_drop = m_drop + 16'd1;
        end
        check("expected_psn", expected_psn, m_psn);
        check("pkt_count", pkt_count, m_pkt);
        check("drop_count", drop_count, m_drop);
        check("status_pulses", n_status - st0, 1);
        check("fwd_beat_count", got_q.size(), exp_q.size());
        nmis = 0;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            if (got_q[i] !== exp_q[i]) nmis++;
        end
        check("fwd_beat_data", nmis, 0);
    endtask

    initial begin
        logic [7:0]  r_op;
        logic [23:0] r_psn;
        logic [31:0] r_len;
        logic [31:0] r_bytes;
        logic [3:0]  r_lk;
        int          r_nb;
        int          st0;
        int          k;

        aresetn = 1'b0; header_valid = 1'b0; rdma_opcode = 8'd0; rdma_psn = 24'd0;
        rdma_remote_addr = 64'd0; rdma_length = 32'd0; psn_load = 1'b0; psn_init = 24'd0;
        s_axis_tdata = 32'd0; s_axis_tkeep = 4'd0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        m_axis_tready = 1'b0; cmd_ready = 1'b0;

        tbl[0]  = '{1'b1, 24'h000010, 8'h0A, 24'h000010, 64'h1000, 32'd16, 4, 4'hF, 0, 3'd0};
        tbl[1]  = '{1'b0, 24'h0,      8'h0A, 24'h000012, 64'h1000, 32'd16, 4, 4'hF, 0, 3'd2};
        tbl[2]  = '{1'b0, 24'h0,      8'h04, 24'h000011, 64'h2000, 32'd16, 4, 4'hF, 0, 3'd1};
        tbl[3]  = '{1'b0, 24'h0,      8'h0A, 24'h000011, 64'h3000, 32'd0,  1, 4'hF, 0, 3'd3};
        tbl[4]  = '{1'b0, 24'h0,      8'h0A, 24'h000011, 64'h4000, 32'd8192, 2, 4'hF, 0, 3'd3};
        tbl[5]  = '{1'b0, 24'h0,      8'h0A, 24'h000011, 64'h5000, 32'd16, 3, 4'h3, 0, 3'd4};
        tbl[6]  = '{1'b0, 24'h0,      8'h0A, 24'h000012, 64'hDEAD_0000_1234_5678, 32'd12, 3, 4'hF, 5, 3'd0};
        tbl[7]  = '{1'b1, 24'hFFFFFF, 8'h0A, 24'hFFFFFF, 64'h0100, 32'd8,  2, 4'hF, 0, 3'd0};
        tbl[8]  = '{1'b0, 24'h0,      8'h0A, 24'h000000, 64'h0200, 32'd4096, 1024, 4'hF, 1, 3'd0};
        tbl[9]  = '{1'b0, 24'h0,      8'h0A, 24'h000001, 64'h0300, 32'd4097, 1, 4'hF, 0, 3'd3};
        tbl[10] = '{1'b0, 24'h0,      8'h0A, 24'h000001, 64'h0400, 32'd1,  1, 4'h1, 0, 3'd0};

        cur_tag = "reset";
        #12;
        check("rst_busy", busy, 1'b0);
        check("rst_cmd_valid", cmd_valid, 1'b0);
        check("rst_status_valid", status_valid, 1'b0);
        check("rst_s_tready", s_axis_tready, 1'b0);
        check("rst_m_tvalid", m_axis_tvalid, 1'b0);
        check("rst_expected_psn", expected_psn, 24'd0);
        check("rst_counts", {pkt_count, drop_count}, 32'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        tick();

        for (int i = 0; i < 11; i++) begin
            cur_tag = $sformatf("vec%0d", i);
            if (tbl[i].ld) load_psn(tbl[i].ld_val);
            run_pkt(tbl[i].op, tbl[i].psn, tbl[i].addr, tbl[i].len, tbl[i].nb, tbl[i].lk,
                    tbl[i].cdel, tbl[i].want);
        end

        // Reset while a packet is mid-payload.
        cur_tag = "reset_mid_stream";
        got_q.delete();
        st0 = n_status;
        rdma_opcode = 8'h0A; rdma_psn = m_psn; rdma_remote_addr = 64'h7000; rdma_length = 32'd16;
        header_valid = 1'b1;
        tick();
        header_valid = 1'b0;
        tick();
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        s_axis_tvalid = 1'b1; s_axis_tdata = 32'hCAFE_0001; s_axis_tkeep = 4'hF; s_axis_tlast = 1'b0;
        m_axis_tready = 1'b1;
        tick();
        check("beat_before_reset", got_q.size(), 1);
        #2;
        aresetn = 1'b0;
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_m_tvalid", m_axis_tvalid, 1'b0);
        check("mid_rst_m_tdata", m_axis_tdata, 32'd0);
        check("mid_rst_s_tready", s_axis_tready, 1'b0);
        check("mid_rst_cmd", {cmd_valid, cmd_addr, cmd_len}, 65'd0);
        check("mid_rst_status", status_valid, 1'b0);
        check("mid_rst_psn", expected_psn, 24'd0);
        check("mid_rst_counts", {pkt_count, drop_count}, 32'd0);
        s_axis_tvalid = 1'b0;
        tick();
        tick();
        aresetn = 1'b1;
        tick();
        check("no_status_after_reset", n_status - st0, 0);
        m_psn = 24'd0; m_pkt = 16'd0; m_drop = 16'd0;

        // Randomized packets judged by the reference model.
        for (int n = 0; n < 40; n++) begin
            cur_tag = $sformatf("rand%0d", n);
            r_op  = ($urandom_range(0, 9) == 0) ? 8'h04 : 8'h0A;
            r_psn = ($urandom_range(0, 7) == 0) ? (m_psn + 24'd2) : m_psn;
            k = $urandom_range(0, 19);
            if (k == 0) begin
                r_len = 32'd0;
                r_nb  = $urandom_range(1, 4);
                r_lk  = 4'hF;
            end else if (k == 1) begin
                r_len = 32'd4097 + $urandom_range(0, 100);
                r_nb  = $urandom_range(1, 4);
                r_lk  = 4'hF;
            end else begin
                r_len = $urandom_range(1, 64);
                r_nb  = (r_len + 3) / 4;
                case (r_len % 4)
                    1: r_lk = 4'h1;
                    2: r_lk = 4'h3;
                    3: r_lk = 4'h7;
                    default: r_lk = 4'hF;
                endcase
                if (r_nb > 1 && $urandom_range(0, 5) == 0) r_nb = r_nb - 1;
            end
            r_bytes = 4 * (r_nb - 1) + ((r_lk == 4'h1) ? 1 : (r_lk == 4'h3) ? 2 : (r_lk == 4'h7) ? 3 : 4);
            run_pkt(r_op, r_psn, {32'h0, $urandom}, r_len, r_nb, r_lk, $urandom_range(0, 3),
                    model_code(r_op, r_psn, r_len, r_bytes));
        end

`ifdef RX_STREAM_TIMEOUT_EN
        cur_tag = "timeout";
        rdma_opcode = 8'h0A; rdma_psn = m_psn; rdma_remote_addr = 64'h9000; rdma_length = 32'd16;
        header_valid = 1'b1;
        tick();
        header_valid = 1'b0;
        tick();
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        s_axis_tvalid = 1'b1; s_axis_tdata = 32'h1; s_axis_tkeep = 4'hF; s_axis_tlast = 1'b0;
        m_axis_tready = 1'b1;
        tick();
        s_axis_tvalid = 1'b0;
        k = 0;
        while (!status_valid && k < 20) begin
            tick();
            k++;
        end
        check("timeout_latency", k, 8);
        check("timeout_code", status_code, 3'd5);
        tick();
        m_drop = m_drop + 16'd1;
        check("timeout_idle", busy, 1'b0);
        check("timeout_drop", drop_count, m_drop);
        check("timeout_psn", expected_psn, m_psn);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
